ps2_host_transmitter: RTL and testbench
=======================================

Name: ps2_host_transmitter

Overview:
Host-to-device side of the PS/2 link; complements the existing PS/2 keyboard receiver on the same ps2_clock/ps2_data pair. Takes a command byte (e.g. 0xED set-LEDs, 0xFF reset) from the central unit and runs the PS/2 request-to-send sequence. Drives open-drain lines via active-high "pull low" enables. Reports done/acknowledge or error. tx_busy gates the receiver while a frame is in flight.

Parameters:
INHIBIT_CYCLES, 6000, clock cycles the host holds ps2_clock low before the request (120 us at 50 MHz)
TIMEOUT_CYCLES, 750000, maximum cycles from request to frame end before aborting (15 ms at 50 MHz)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
tx_data  in  8  byte to send; sampled on the accepted tx_start cycle
tx_start  in  1  one-cycle request; accepted only while tx_busy=0
tx_busy  out  1  high from the cycle after acceptance until done/error is pulsed
tx_done  out  1  one-cycle pulse: frame sent and device ACK seen
tx_error  out  1  one-cycle pulse: missing ACK or timeout
ps2_clock_in  in  1  raw PS/2 clock line (asynchronous)
ps2_data_in  in  1  raw PS/2 data line (asynchronous)
ps2_clock_drive_low  out  1  1 = pull ps2_clock low, 0 = release
ps2_data_drive_low  out  1  1 = pull ps2_data low, 0 = release

Behaviour:
- Reset (async): state IDLE; all outputs 0; lines released; counters cleared. Reset mid-frame releases both lines within the reset itself, not on the next clock.
- ps2_clock_in and ps2_data_in each pass through a 2-flop synchronizer. A falling edge (fe) is sync-clock prev=1, now=0: a 1-cycle pulse, 3 clocks after the pin edge.
- Frame register: {parity, tx_data}; parity = ~^tx_data (odd parity). Latched on acceptance.
- States:
  - IDLE: lines released. On tx_start, latch the frame, clear the counters and go to INHIBIT. tx_busy=1 from the next cycle.
  - INHIBIT: clock_drive_low=1 for INHIBIT_CYCLES cycles. On the last cycle, assert data_drive_low=1 (start bit) and go to REQUEST.
  - REQUEST: clock_drive_low=0, data_drive_low=1. The timeout counter starts here. On fe: present bit0 and go to SEND with bit_idx=1.
  - SEND: on each fe, present the next bit. data_drive_low = ~bit. Order: data bits 0..7 (LSB first), then parity on the 9th fe.
  - 10th fe: release data (stop bit) and go to ACK.
  - ACK: on the 11th fe, sample sync data. 0 → WAIT_IDLE. 1 → ERROR.
  - WAIT_IDLE: wait until sync clock=1 and sync data=1 together. Then pulse tx_done, clear tx_busy and go to IDLE.
  - ERROR: release both lines, pulse tx_error, clear tx_busy and go to IDLE.
- Timeout: a counter runs from entry to REQUEST until exit from WAIT_IDLE. When it reaches TIMEOUT_CYCLES in REQUEST, SEND, ACK or WAIT_IDLE, go to ERROR.
- tx_done and tx_error are mutually exclusive, 1 cycle each, each followed by tx_busy=0 in the same cycle.
- tx_start while tx_busy=1 is ignored; the frame in flight is unaffected.
- tx_start in the same cycle as a done/error pulse is ignored. A new start is accepted from the next cycle.
- Device edges during INHIBIT (device still finishing a transmission) are ignored. The inhibit aborts that transmission per protocol.
- Data changes only on fe, so it is stable before the device's rising-edge sample.

Test Plan:
1. INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000; device model clocks at 40 cycles/half-period and ACKs; tx_data=0xED → clock held low exactly 10 cycles. Sampled bits: start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done pulses once, tx_error stays 0.
2. Parity bytes, device ACKs → sampled parity 1 for 0x00, 1 for 0xFF, 0 for 0x01, 0 for 0xF4.
3. Device releases data on the 11th clock (no ACK), tx_data=0xFF → tx_error pulses 1 cycle after the 11th fe is detected. tx_done=0; both drive_low outputs 0.
4. Device never clocks → tx_error exactly TIMEOUT_CYCLES after REQUEST entry. data_drive_low returns to 0 and tx_busy=0.
5. Second tx_start (0x55) mid-frame of 0xED → ignored; only 0xED is sampled; one tx_done.
6. Assert reset at data bit 4 → both drive_low=0 and tx_busy=0 immediately (asynchronous). After release, a fresh 0xF4 frame completes with tx_done.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send and
// clocks out one command byte (odd parity) under device clocking, then checks the ACK.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        WAIT_IDLE,
        ERROR
    } state_t;

    state_t            state;
    logic [8:0]        frame;
    logic [3:0]        bit_idx;
    logic [INH_W-1:0]  inhibit_cnt;
    logic [TO_W-1:0]   timeout_cnt;
    logic              clock_meta, clock_sync, clock_prev;
    logic              data_meta, data_sync;
    logic              fe;
    logic              timed_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clock_meta <= 1'b1;
            clock_sync <= 1'b1;
            clock_prev <= 1'b1;
            data_meta  <= 1'b1;
            data_sync  <= 1'b1;
        end else begin
            clock_meta <= ps2_clock_in;
            clock_sync <= clock_meta;
            clock_prev <= clock_sync;
            data_meta  <= ps2_data_in;
            data_sync  <= data_meta;
        end
    end

    assign fe = clock_prev & ~clock_sync;

    // The ERROR state costs one cycle before tx_error, so abort one count early
    // to land the pulse exactly TIMEOUT_CYCLES after REQUEST entry.
    assign timed_out = (state inside {REQUEST, SEND, ACK, WAIT_IDLE}) &&
                       (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            frame               <= '0;
            bit_idx             <= '0;
            inhibit_cnt         <= '0;
            timeout_cnt         <= '0;
            tx_busy             <= 1'b0;
            tx_done             <= 1'b0;
            tx_error            <= 1'b0;
            ps2_clock_drive_low <= 1'b0;
            ps2_data_drive_low  <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (state inside {REQUEST, SEND, ACK, WAIT_IDLE}) begin
                timeout_cnt <= timeout_cnt + TO_W'(1);
            end

            if (timed_out) begin
                ps2_clock_drive_low <= 1'b0;
                ps2_data_drive_low  <= 1'b0;
                state               <= ERROR;
            end else begin
                case (state)
                    IDLE: begin
                        ps2_clock_drive_low <= 1'b0;
                        ps2_data_drive_low  <= 1'b0;
                        // A start coinciding with a done/error pulse is dropped.
                        if (tx_start && !tx_done && !tx_error) begin
                            frame               <= {~^tx_data, tx_data};
                            inhibit_cnt         <= '0;
                            timeout_cnt         <= '0;
                            bit_idx             <= '0;
                            tx_busy             <= 1'b1;
                            ps2_clock_drive_low <= 1'b1;
                            state               <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inhibit_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                            ps2_clock_drive_low <= 1'b0;
                            ps2_data_drive_low  <= 1'b1;
                            timeout_cnt         <= TO_W'(1);
                            state               <= REQUEST;
                        end else begin
                            inhibit_cnt <= inhibit_cnt + INH_W'(1);
                        end
                    end
                    REQUEST: begin
                        if (fe) begin
                            ps2_data_drive_low <= ~frame[0];
                            frame              <= {1'b0, frame[8:1]};
                            bit_idx            <= 4'd1;
                            state              <= SEND;
                        end
                    end
                    // frame shifts right so bit 0 always holds the next bit to present
                    SEND: begin
                        if (fe) begin
                            if (bit_idx == 4'd9) begin
                                ps2_data_drive_low <= 1'b0;
                                state              <= ACK;
                            end else begin
                                ps2_data_drive_low <= ~frame[0];
                                frame              <= {1'b0, frame[8:1]};
                                bit_idx            <= bit_idx + 4'd1;
                            end
                        end
                    end
                    ACK: begin
                        if (fe) begin
                            state <= data_sync ? ERROR : WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clock_sync && data_sync) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    ERROR: begin
                        ps2_clock_drive_low <= 1'b0;
                        ps2_data_drive_low  <= 1'b0;
                        tx_error            <= 1'b1;
                        tx_busy             <= 1'b0;
                        state               <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a clock-generating PS/2 device model
// on a wired-AND bus.
module tb_ps2_host_transmitter;

    localparam int INHIBIT = 10;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clock_drive_low, ps2_data_drive_low;
    logic       ps2_clock_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int done_count = 0;
    int error_count = 0;
    int run = 0;
    int last_run = 0;
    int req_cycle = 0;
    int err_cycle = 0;
    int dev_falls = 0;
    logic prev_data_low = 1'b0;

    assign ps2_clock_in = dev_clk & ~ps2_clock_drive_low;
    assign ps2_data_in  = dev_data & ~ps2_data_drive_low;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clock_in(ps2_clock_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clock_drive_low(ps2_clock_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low)
    );

    always #10 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Pulse counters and timing marks, sampled on the inactive edge.
    always @(negedge clock) begin
        if (tx_done) done_count++;
        if (tx_error) begin
            error_count++;
            err_cycle = cycle_cnt;
        end
        if (ps2_clock_drive_low) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (ps2_data_drive_low && !prev_data_low) req_cycle = cycle_cnt;
        prev_data_low = ps2_data_drive_low;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    // Device: waits for the request, samples data before each falling edge, ACKs on the 11th.
    task automatic device_frame(input bit do_ack, output logic [10:0] bits,
                                output bit got_req, output int fall11_cycle);
        got_req = 1'b0;
        bits = '0;
        fall11_cycle = 0;
        for (int i = 0; i < 200 && !got_req; i++) begin
            @(negedge clock);
            if (ps2_data_drive_low && !ps2_clock_drive_low) got_req = 1'b1;
        end
        if (got_req) begin
            repeat (20) @(negedge clock);
            for (int k = 0; k < 11; k++) begin
                bits[k] = ps2_data_in;
                if (k == 10) begin
                    fall11_cycle = cycle_cnt;
                    if (do_ack) dev_data = 1'b0;
                end
                dev_clk = 1'b0;
                dev_falls++;
                repeat (HALF) @(negedge clock);
                dev_clk = 1'b1;
                repeat (HALF) @(negedge clock);
            end
            dev_data = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit do_ack, output logic [10:0] bits,
                             output bit got_req, output int fall11_cycle);
        start_tx(d);
        device_frame(do_ack, bits, got_req, fall11_cycle);
        repeat (60) @(posedge clock);
    endtask

    task automatic wait_end(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (tx_done || tx_error) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        #5;
        checks++;
        if ({tx_busy, tx_done, tx_error, ps2_clock_drive_low, ps2_data_drive_low} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {tx_busy, tx_done, tx_error, ps2_clock_drive_low, ps2_data_drive_low});
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_basic_frame();
        logic [10:0] bits;
        bit got_req;
        int f11;
        int d0 = done_count;
        int e0 = error_count;
        run_frame(8'hED, 1'b1, bits, got_req, f11);
        checks++;
        if (got_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_request: got %0b expected 1", got_req); end
        checks++;
        if (last_run !== INHIBIT) begin errors++; $display("[TB] FAIL inhibit_length: got %0d expected %0d", last_run, INHIBIT); end
        checks++;
        if (bits !== 11'b11_11101101_0) begin errors++; $display("[TB] FAIL basic_bits: got %b expected %b", bits, 11'b11_11101101_0); end
        checks++;
        if (done_count - d0 !== 1) begin errors++; $display("[TB] FAIL basic_done: got %0d expected 1", done_count - d0); end
        checks++;
        if (error_count - e0 !== 0) begin errors++; $display("[TB] FAIL basic_error: got %0d expected 0", error_count - e0); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 0", tx_busy); end
    endtask

    task automatic test_parity();
        logic [7:0]  bytes [4];
        logic [10:0] expect_bits [4];
        logic [10:0] bits;
        bit got_req;
        int f11;
        int d0;
        bytes[0] = 8'h00; expect_bits[0] = 11'b11_00000000_0;
        bytes[1] = 8'hFF; expect_bits[1] = 11'b11_11111111_0;
        bytes[2] = 8'h01; expect_bits[2] = 11'b10_00000001_0;
        bytes[3] = 8'hF4; expect_bits[3] = 11'b10_11110100_0;
        for (int i = 0; i < 4; i++) begin
            d0 = done_count;
            run_frame(bytes[i], 1'b1, bits, got_req, f11);
            checks++;
            if (bits !== expect_bits[i]) begin
                errors++;
                $display("[TB] FAIL parity_bits_%0h: got %b expected %b", bytes[i], bits, expect_bits[i]);
            end
            checks++;
            if (done_count - d0 !== 1) begin
                errors++;
                $display("[TB] FAIL parity_done_%0h: got %0d expected 1", bytes[i], done_count - d0);
            end
        end
    endtask

    task automatic test_no_ack();
        logic [10:0] bits;
        bit got_req;
        int f11;
        int d0 = done_count;
        int e0 = error_count;
        run_frame(8'hFF, 1'b0, bits, got_req, f11);
        checks++;
        if (error_count - e0 !== 1) begin errors++; $display("[TB] FAIL noack_error: got %0d expected 1", error_count - e0); end
        checks++;
        if (done_count - d0 !== 0) begin errors++; $display("[TB] FAIL noack_done: got %0d expected 0", done_count - d0); end
        checks++;
        if (err_cycle - f11 !== 4) begin errors++; $display("[TB] FAIL noack_latency: got %0d expected 4", err_cycle - f11); end
        checks++;
        if ({ps2_clock_drive_low, ps2_data_drive_low, tx_busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL noack_lines: got %b expected 000", {ps2_clock_drive_low, ps2_data_drive_low, tx_busy});
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int d0 = done_count;
        int e0 = error_count;
        start_tx(8'hA5);
        wait_end(TIMEOUT + 200, seen);
        repeat (3) @(posedge clock);
        checks++;
        if (seen !== 1'b1 || error_count - e0 !== 1 || done_count - d0 !== 0) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got errors=%0d dones=%0d expected 1 and 0",
                     error_count - e0, done_count - d0);
        end
        checks++;
        if (err_cycle - req_cycle !== TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: got %0d expected %0d", err_cycle - req_cycle, TIMEOUT);
        end
        checks++;
        if ({ps2_data_drive_low, tx_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL timeout_release: got %b expected 00", {ps2_data_drive_low, tx_busy});
        end
    endtask

    task automatic test_ignored_start();
        logic [10:0] bits;
        bit got_req;
        int f11;
        int d0 = done_count;
        start_tx(8'hED);
        fork
            device_frame(1'b1, bits, got_req, f11);
            begin
                repeat (300) @(negedge clock);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
            end
        join
        repeat (60) @(posedge clock);
        checks++;
        if (bits !== 11'b11_11101101_0) begin errors++; $display("[TB] FAIL ignored_bits: got %b expected %b", bits, 11'b11_11101101_0); end
        checks++;
        if (done_count - d0 !== 1) begin errors++; $display("[TB] FAIL ignored_done: got %0d expected 1", done_count - d0); end
        checks++;
        if ({ps2_clock_drive_low, tx_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ignored_idle: got %b expected 00", {ps2_clock_drive_low, tx_busy});
        end
    endtask

    task automatic test_start_during_done();
        logic [10:0] bits;
        bit got_req;
        bit seen;
        int f11;
        start_tx(8'h01);
        seen = 1'b0;
        fork
            device_frame(1'b1, bits, got_req, f11);
            begin
                for (int i = 0; i < 2000 && !seen; i++) begin
                    @(negedge clock);
                    if (tx_done) seen = 1'b1;
                end
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
            end
        join
        repeat (20) @(negedge clock);
        checks++;
        if (seen !== 1'b1) begin errors++; $display("[TB] FAIL done_seen: got %0b expected 1", seen); end
        checks++;
        if ({ps2_clock_drive_low, tx_busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL start_on_done: got %b expected 00", {ps2_clock_drive_low, tx_busy});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        bit got_req;
        int f11;
        int base;
        int d0;
        logic [2:0] before_reset;
        start_tx(8'hED);
        base = dev_falls;
        before_reset = '0;
        fork
            device_frame(1'b1, bits, got_req, f11);
            begin
                for (int i = 0; i < 2000 && dev_falls < base + 5; i++) @(negedge clock);
                repeat (5) @(negedge clock);
                before_reset = {ps2_clock_drive_low, ps2_data_drive_low, tx_busy};
                #3;
                reset = 1'b1;
                #1;
                checks++;
                if ({ps2_clock_drive_low, ps2_data_drive_low, tx_busy} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL async_reset_release: got %b expected 000",
                             {ps2_clock_drive_low, ps2_data_drive_low, tx_busy});
                end
                repeat (3) @(negedge clock);
                reset = 1'b0;
            end
        join
        checks++;
        if (before_reset !== 3'b011) begin
            errors++;
            $display("[TB] FAIL bit4_state: got %b expected 011", before_reset);
        end
        repeat (10) @(negedge clock);
        d0 = done_count;
        run_frame(8'hF4, 1'b1, bits, got_req, f11);
        checks++;
        if (bits !== 11'b10_11110100_0) begin errors++; $display("[TB] FAIL post_reset_bits: got %b expected %b", bits, 11'b10_11110100_0); end
        checks++;
        if (done_count - d0 !== 1) begin errors++; $display("[TB] FAIL post_reset_done: got %0d expected 1", done_count - d0); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_no_ack();
        test_timeout();
        test_ignored_start();
        test_start_during_done();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
